// File: rtl/mac_operand_sequencer_if.sv
// Operand/result bundle between the MAC operand sequencer and its surroundings:
// layer controller handshake, image and weight RAM read ports, MAC operand
// and control lines, and the result stream.
// master = the sequencer, slave = the RAMs, MAC and controller side.
interface mac_operand_sequencer_if #(
    parameter int ADDR_W = 11
);
    // layer controller handshake
    logic                     start;
    logic [1:0]               layer;
    logic                     busy;
    logic                     done;

    // image / activation RAM read port (synchronous, one cycle latency)
    logic [ADDR_W-1:0]        img_addr;
    logic signed [15:0]       img_rdata;

    // weight RAM read port (synchronous, one cycle latency)
    logic [ADDR_W-1:0]        wgt_addr;
    logic signed [15:0]       wgt_rdata;

    // MAC operand side
    logic                     mac_clr;
    logic                     mac_enable;
    logic [1:0]               mac_layer;
    logic signed [15:0]       mac_A;
    logic signed [15:0]       mac_B;
    logic signed [31:0]       mac_out;

    // result stream
    logic                     res_valid;
    logic signed [31:0]       res_data;
    logic [9:0]               res_index;

    modport master (
        input  start, layer, img_rdata, wgt_rdata, mac_out,
        output busy, done, img_addr, wgt_addr,
               mac_clr, mac_enable, mac_layer, mac_A, mac_B,
               res_valid, res_data, res_index
    );

    modport slave (
        output start, layer, img_rdata, wgt_rdata, mac_out,
        input  busy, done, img_addr, wgt_addr,
               mac_clr, mac_enable, mac_layer, mac_A, mac_B,
               res_valid, res_data, res_index
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// MAC operand sequencer: walks the image and weight RAMs for one layer
// (conv 5x5 on a 28x28 or 12x12 input, or one FC stage), feeds the MAC one
// operand pair per cycle, adds the flush cycle the MAC needs to latch its sum,
// and emits each finished sum tagged with its output index.
// Optional build macro RELU_EN: when defined, negative sums are emitted as 0.
module mac_operand_sequencer #(
    parameter int K       = 5,
    parameter int CONV1_W = 28,
    parameter int CONV2_W = 12,
    parameter int FC_LEN  = 192,
    parameter int FC_OUTS = 10,
    parameter int ADDR_W  = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    mac_operand_sequencer_if.master       bus
);

    // Counter widths: tap counter must hold FC_LEN-1, column counter the
    // widest conv output row, output index the largest output count.
    localparam int CNT_W = $clog2(FC_LEN);
    localparam int POS_W = $clog2(CONV1_W);
    localparam int IDX_W = 10;

    localparam int TAPS   = K * K;
    localparam int WOUT1  = CONV1_W - K + 1;
    localparam int WOUT2  = CONV2_W - K + 1;

    localparam logic [1:0] LAYER_CONV1   = 2'b00;
    localparam logic [1:0] LAYER_FC      = 2'b10;
    localparam logic [1:0] LAYER_ILLEGAL = 2'b11;

    localparam logic [ADDR_W-1:0] W1_A        = ADDR_W'(CONV1_W);
    localparam logic [ADDR_W-1:0] W2_A        = ADDR_W'(CONV2_W);
    localparam logic [ADDR_W-1:0] KM1_A       = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] FC_LEN_A    = ADDR_W'(FC_LEN);
    localparam logic [POS_W-1:0]  J_LAST      = POS_W'(K - 1);
    localparam logic [POS_W-1:0]  WOUT1_LAST  = POS_W'(WOUT1 - 1);
    localparam logic [POS_W-1:0]  WOUT2_LAST  = POS_W'(WOUT2 - 1);
    localparam logic [CNT_W-1:0]  CONV_T_LAST = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]  FC_T_LAST   = CNT_W'(FC_LEN - 1);
    localparam logic [IDX_W-1:0]  OUT1_LAST   = IDX_W'(WOUT1 * WOUT1 - 1);
    localparam logic [IDX_W-1:0]  OUT2_LAST   = IDX_W'(WOUT2 * WOUT2 - 1);
    localparam logic [IDX_W-1:0]  FC_O_LAST   = IDX_W'(FC_OUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FLUSH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state_reg;

    // registered outputs
    logic                 busy_reg;
    logic                 done_reg;
    logic [ADDR_W-1:0]    img_addr_reg;
    logic [ADDR_W-1:0]    wgt_addr_reg;
    logic                 mac_clr_reg;
    logic                 mac_enable_reg;
    logic [1:0]           layer_reg;
    logic                 res_valid_reg;
    logic signed [31:0]   res_data_reg;
    logic [IDX_W-1:0]     res_index_reg;

    // walk state
    logic [CNT_W-1:0]     tap_cnt_reg;    // product number within the output
    logic [POS_W-1:0]     j_reg;          // kernel column of the current tap
    logic [ADDR_W-1:0]    tap_off_reg;    // i*W + j of the current tap
    logic [POS_W-1:0]     c_reg;          // output column
    logic [ADDR_W-1:0]    out_base_reg;   // r*W + c of the current output
    logic [ADDR_W-1:0]    wgt_base_reg;   // o*FC_LEN of the current FC output
    logic [IDX_W-1:0]     out_idx_reg;    // output number within the run

    // per-layer geometry, decoded from the latched layer code
    logic                 is_fc;
    logic                 is_conv1;
    logic [ADDR_W-1:0]    w_sel;
    logic [POS_W-1:0]     wout_last;
    logic [CNT_W-1:0]     tap_last;
    logic [IDX_W-1:0]     out_last;

    // next-step values for the tap and output walks
    logic [POS_W-1:0]     j_next;
    logic [ADDR_W-1:0]    tap_off_next;
    logic [POS_W-1:0]     c_next;
    logic [ADDR_W-1:0]    out_base_next;
    logic [ADDR_W-1:0]    wgt_base_next;

    logic signed [31:0]   capture_val;

    // Decode layer geometry from the layer latched at start.
    always_comb begin
        is_fc    = (layer_reg == LAYER_FC);
        is_conv1 = (layer_reg == LAYER_CONV1);
        w_sel     = is_conv1 ? W1_A : W2_A;
        wout_last = is_conv1 ? WOUT1_LAST : WOUT2_LAST;
        tap_last  = is_fc ? FC_T_LAST : CONV_T_LAST;
        if (is_fc) begin
            out_last = FC_O_LAST;
        end else if (is_conv1) begin
            out_last = OUT1_LAST;
        end else begin
            out_last = OUT2_LAST;
        end
    end

    // Next tap: j runs fastest; wrapping j steps the offset down one image row.
    always_comb begin
        j_next       = j_reg + 1'b1;
        tap_off_next = tap_off_reg + 1'b1;
        if (j_reg == J_LAST) begin
            j_next       = '0;
            tap_off_next = tap_off_reg + w_sel - KM1_A;
        end
    end

    // Next output: c runs fastest; wrapping c moves the base to the next row.
    always_comb begin
        c_next        = c_reg + 1'b1;
        out_base_next = out_base_reg + 1'b1;
        if (c_reg == wout_last) begin
            c_next        = '0;
            out_base_next = out_base_reg + w_sel - ADDR_W'(wout_last);
        end
        wgt_base_next = wgt_base_reg + FC_LEN_A;
    end

`ifdef RELU_EN
    // Rectify the finished sum before it is emitted.
    always_comb begin
        capture_val = bus.mac_out[31] ? 32'sd0 : bus.mac_out;
    end
`else
    // Emit the finished sum unchanged, sign included.
    always_comb begin
        capture_val = bus.mac_out;
    end
`endif

    // Sequencer FSM: one address per ISSUE cycle, then drain, flush, capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            img_addr_reg   <= '0;
            wgt_addr_reg   <= '0;
            mac_clr_reg    <= 1'b0;
            mac_enable_reg <= 1'b0;
            layer_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_index_reg  <= '0;
            tap_cnt_reg    <= '0;
            j_reg          <= '0;
            tap_off_reg    <= '0;
            c_reg          <= '0;
            out_base_reg   <= '0;
            wgt_base_reg   <= '0;
            out_idx_reg    <= '0;
        end else begin
            // single-cycle pulses
            mac_clr_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            done_reg      <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (bus.start && (bus.layer != LAYER_ILLEGAL)) begin
                        layer_reg      <= bus.layer;
                        mac_clr_reg    <= 1'b1;
                        busy_reg       <= 1'b1;
                        mac_enable_reg <= 1'b0;
                        tap_cnt_reg    <= '0;
                        j_reg          <= '0;
                        tap_off_reg    <= '0;
                        c_reg          <= '0;
                        out_base_reg   <= '0;
                        wgt_base_reg   <= '0;
                        out_idx_reg    <= '0;
                        img_addr_reg   <= '0;
                        wgt_addr_reg   <= '0;
                        state_reg      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // the RAM answers the current address next cycle
                    mac_enable_reg <= 1'b1;
                    if (tap_cnt_reg == tap_last) begin
                        img_addr_reg <= '0;
                        wgt_addr_reg <= '0;
                        state_reg    <= S_DRAIN;
                    end else begin
                        tap_cnt_reg  <= tap_cnt_reg + 1'b1;
                        j_reg        <= j_next;
                        tap_off_reg  <= tap_off_next;
                        img_addr_reg <= is_fc ? (img_addr_reg + 1'b1)
                                              : (out_base_reg + tap_off_next);
                        // weights are contiguous per output for both layer kinds
                        wgt_addr_reg <= wgt_addr_reg + 1'b1;
                    end
                end

                S_DRAIN: begin
                    // last data cycle is on the bus; keep enable for the flush
                    mac_enable_reg <= 1'b1;
                    state_reg      <= S_FLUSH;
                end

                S_FLUSH: begin
                    // MAC latches its sum at the end of this cycle
                    mac_enable_reg <= 1'b0;
                    state_reg      <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    res_data_reg  <= capture_val;
                    res_index_reg <= out_idx_reg;
                    res_valid_reg <= 1'b1;
                    if (out_idx_reg == out_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        out_idx_reg  <= out_idx_reg + 1'b1;
                        c_reg        <= c_next;
                        out_base_reg <= out_base_next;
                        if (is_fc) begin
                            wgt_base_reg <= wgt_base_next;
                        end
                        tap_cnt_reg  <= '0;
                        j_reg        <= '0;
                        tap_off_reg  <= '0;
                        img_addr_reg <= is_fc ? '0 : out_base_next;
                        wgt_addr_reg <= is_fc ? wgt_base_next : '0;
                        state_reg    <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Operands pass through only while the MAC is enabled.
    assign bus.mac_A = mac_enable_reg ? bus.img_rdata : 16'sd0;
    assign bus.mac_B = mac_enable_reg ? bus.wgt_rdata : 16'sd0;

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.img_addr   = img_addr_reg;
    assign bus.wgt_addr   = wgt_addr_reg;
    assign bus.mac_clr    = mac_clr_reg;
    assign bus.mac_enable = mac_enable_reg;
    assign bus.mac_layer  = layer_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_data   = res_data_reg;
    assign bus.res_index  = res_index_reg;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: synchronous image/weight RAMs, a small
// behavioural MAC (accumulate while enabled, latch on count == N), and
// directed layer runs with hand-computed results.
module tb_mac_operand_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int total = 0;
    int bad   = 0;

    mac_operand_sequencer_if #(.ADDR_W(11)) sif ();

    mac_operand_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAMs
    logic signed [15:0] img_mem [0:2047];
    logic signed [15:0] wgt_mem [0:2047];

    always @(posedge clk) begin
        sif.img_rdata <= img_mem[sif.img_addr];
        sif.wgt_rdata <= wgt_mem[sif.wgt_addr];
    end

    // behavioural MAC
    logic signed [31:0] acc;
    logic signed [31:0] mac_res;
    int                 mcount;
    int                 mac_n;

    assign mac_n = (sif.mac_layer == 2'b10) ? 192 : 25;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= 0;
            mac_res <= 0;
            mcount  <= 0;
        end else if (sif.mac_clr) begin
            acc    <= 0;
            mcount <= 0;
        end else if (sif.mac_enable) begin
            if (mcount == mac_n) begin
                mac_res <= acc;
                acc     <= 0;
                mcount  <= 0;
            end else begin
                acc    <= acc + sif.mac_A * sif.mac_B;
                mcount <= mcount + 1;
            end
        end
    end
    assign sif.mac_out = mac_res;

    // run monitor
    int rd_q[$];
    int ri_q[$];
    int rc_q[$];
    int ra_q[$];
    int tap_q[$];
    int done_cnt, busy_cnt, en_cnt, gate_bad, max_wgt;

    always @(negedge clk) begin
        if (!reset) begin
            if (sif.res_valid) begin
                rd_q.push_back(int'(sif.res_data));
                ri_q.push_back(int'(sif.res_index));
                rc_q.push_back(cyc);
                ra_q.push_back(int'(sif.wgt_addr));
            end
            if (sif.done) done_cnt++;
            if (sif.busy) busy_cnt++;
            if (sif.mac_enable) en_cnt++;
            else if (sif.mac_A != 16'sd0 || sif.mac_B != 16'sd0) gate_bad++;
            if (sif.busy && sif.wgt_addr == 11'd24) tap_q.push_back(int'(sif.img_addr));
            if (int'(sif.wgt_addr) > max_wgt) max_wgt = int'(sif.wgt_addr);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete(); ri_q.delete(); rc_q.delete(); ra_q.delete(); tap_q.delete();
        done_cnt = 0; busy_cnt = 0; en_cnt = 0; gate_bad = 0; max_wgt = 0;
    endtask

    task automatic fill_mem(input int img_mode, input int wgt_mode);
        for (int a = 0; a < 2048; a++) begin
            img_mem[a] = (img_mode == 0) ? 16'sd1 : 16'(a);
            case (wgt_mode)
                0:       wgt_mem[a] = 16'sd1;
                1:       wgt_mem[a] = 16'sd2;
                default: wgt_mem[a] = (a == 24) ? -16'sd1 : 16'sd0;
            endcase
        end
    endtask

    task automatic pulse_start(input logic [1:0] l, output int s);
        @(negedge clk);
        sif.layer = l;
        sif.start = 1'b1;
        s = cyc;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    // One run; poke > 0 pulses an extra start (layer 00) that many cycles in.
    task automatic run_layer(input logic [1:0] l, input string tag, input int poke, output int s);
        int k;
        clear_mon();
        pulse_start(l, s);
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            k++;
            if (poke > 0 && k == poke) sif.start = 1'b1;
            else sif.start = 1'b0;
            if (poke > 0 && k == poke) sif.layer = 2'b00;
        end
        sif.start = 1'b0;
        chk({tag, "_done_seen"}, longint'(done_cnt > 0), 1);
        repeat (5) @(negedge clk);
        $display("run %s: layer=%0d results=%0d done=%0d busy_cycles=%0d", tag, l, rd_q.size(), done_cnt, busy_cnt);
    endtask

    function automatic int conv_exp(input int k, input int w, input int wout);
        int v;
        v = -(((k / wout) + 4) * w + (k % wout) + 4);
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    int s;
    int derr, ierr, serr;

    initial begin
        sif.start = 1'b0;
        sif.layer = 2'b00;
        fill_mem(0, 0);
        clear_mon();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", sif.busy, 0);
        chk("rst_img_addr", sif.img_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_done", sif.done, 0);
        chk("idle_res_valid", sif.res_valid, 0);
        chk("idle_mac_enable", sif.mac_enable, 0);
        chk("idle_mac_clr", sif.mac_clr, 0);
        chk("idle_wgt_addr", sif.wgt_addr, 0);
        chk("idle_res_data", sif.res_data, 0);
        chk("idle_mac_A", sif.mac_A, 0);

        // layer 00, all ones
        run_layer(2'b00, "conv1_ones", 0, s);
        chk("conv1_count", rd_q.size(), 576);
        derr = 0; ierr = 0;
        foreach (rd_q[k]) begin
            if (rd_q[k] != 25) derr++;
            if (ri_q[k] != k) ierr++;
        end
        chk("conv1_data_errs", derr, 0);
        chk("conv1_index_errs", ierr, 0);
        chk("conv1_done_cnt", done_cnt, 1);
        chk("conv1_busy_cycles", busy_cnt, 576 * 28 + 1);
        chk("conv1_latency", (rc_q.size() > 0) ? rc_q[0] - s : -1, 29);
        chk("conv1_enable_cycles", en_cnt, 576 * 26);
        chk("conv1_gate_errs", gate_bad, 0);

        // FC: img = 1, wgt = 2
        fill_mem(0, 1);
        run_layer(2'b10, "fc", 0, s);
        chk("fc_count", rd_q.size(), 10);
        derr = 0; ierr = 0; serr = 0;
        foreach (rd_q[k]) begin
            if (rd_q[k] != 384) derr++;
            if (ri_q[k] != k) ierr++;
            if (k > 0 && rc_q[k] - rc_q[k-1] != 195) serr++;
        end
        chk("fc_data_errs", derr, 0);
        chk("fc_index_errs", ierr, 0);
        chk("fc_spacing_errs", serr, 0);
        chk("fc_latency", (rc_q.size() > 0) ? rc_q[0] - s : -1, 196);
        chk("fc_o9_first_wgt", (ra_q.size() > 8) ? ra_q[8] : -1, 1728);
        chk("fc_o9_last_wgt", max_wgt, 1919);
        chk("fc_gate_errs", gate_bad, 0);

        // layer 00, img = address, single weight w[24] = -1
        fill_mem(1, 2);
        run_layer(2'b00, "conv1_tap", 0, s);
        chk("conv1_tap_count", rd_q.size(), 576);
        chk("conv1_o1_tap44_img", (tap_q.size() > 1) ? tap_q[1] : -1, 117);
        chk("conv1_o0_data", (rd_q.size() > 0) ? rd_q[0] : 1, conv_exp(0, 28, 24));
        chk("conv1_o1_data", (rd_q.size() > 1) ? rd_q[1] : 1, conv_exp(1, 28, 24));
        derr = 0;
        foreach (rd_q[k]) if (rd_q[k] != conv_exp(k, 28, 24)) derr++;
        chk("conv1_tap_data_errs", derr, 0);

        // layer 01 with a start pulse (layer 00) arriving mid-run
        run_layer(2'b01, "conv2_poke", 100, s);
        chk("conv2_count", rd_q.size(), 64);
        chk("conv2_last_tap_img", (tap_q.size() > 63) ? tap_q[63] : -1, 143);
        chk("conv2_last_data", (rd_q.size() > 63) ? rd_q[63] : 1, conv_exp(63, 12, 8));
        derr = 0;
        foreach (rd_q[k]) if (rd_q[k] != conv_exp(k, 12, 8)) derr++;
        chk("conv2_data_errs", derr, 0);
        chk("conv2_done_cnt", done_cnt, 1);
        chk("conv2_busy_cycles", busy_cnt, 64 * 28 + 1);

        // illegal layer code
        clear_mon();
        pulse_start(2'b11, s);
        repeat (40) @(negedge clk);
        $display("run illegal: layer=3 results=%0d done=%0d busy_cycles=%0d", rd_q.size(), done_cnt, busy_cnt);
        chk("illegal_busy", busy_cnt, 0);
        chk("illegal_results", rd_q.size(), 0);
        chk("illegal_done", done_cnt, 0);

        // reset during ISSUE of output 3
        clear_mon();
        pulse_start(2'b00, s);
        for (int k = 0; k < 400 && rd_q.size() < 3; k++) @(negedge clk);
        chk("abort_reached_o3", rd_q.size(), 3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", sif.busy, 0);
        chk("abort_img_addr", sif.img_addr, 0);
        chk("abort_mac_enable", sif.mac_enable, 0);
        chk("abort_res_data", sif.res_data, 0);
        chk("abort_res_index", sif.res_index, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        $display("run abort: results_before_reset=%0d", rd_q.size());

        fill_mem(0, 0);
        run_layer(2'b01, "conv2_after_reset", 0, s);
        chk("rerun_count", rd_q.size(), 64);
        chk("rerun_first_index", (ri_q.size() > 0) ? ri_q[0] : -1, 0);
        chk("rerun_first_data", (rd_q.size() > 0) ? rd_q[0] : -1, 25);
        derr = 0;
        foreach (rd_q[k]) if (rd_q[k] != 25 || ri_q[k] != k) derr++;
        chk("rerun_errs", derr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Drives the MAC datapath from the other side of its operand interface: walks image and weight memories, presents A/B operand pairs, and issues the extra flush cycle the MAC needs.
- Captures each finished MAC sum and emits it with its output index.
- Sits between the on-chip feature/weight RAMs and the MAC, under control of the layer controller (start/done).
- One run processes one layer: conv 5x5 (layer 00 / 01) or one FC stage (layer 10).

Parameters:
- K, 5, kernel side; conv taps per output = K*K (must equal the MAC's conv count, 25).
- CONV1_W, 28, input width/height for layer 00.
- CONV2_W, 12, input width/height for layer 01.
- FC_LEN, 192, products per FC output (must equal the MAC's FC count).
- FC_OUTS, 10, FC outputs per run.
- ADDR_W, 11, width of both memory address buses.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- layer  in  2  00 = conv1, 01 = conv2, 10 = FC; 11 is illegal.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the last result is emitted.
- img_addr  out  ADDR_W  image/activation RAM read address.
- img_rdata  in  16  signed activation; valid 1 cycle after img_addr (synchronous RAM).
- wgt_addr  out  ADDR_W  weight RAM read address.
- wgt_rdata  in  16  signed weight; valid 1 cycle after wgt_addr.
- mac_clr  out  1  pulse to the MAC reset; resynchronises its internal count.
- mac_enable  out  1  MAC enable.
- mac_layer  out  2  layer code forwarded to the MAC; held for the whole run.
- mac_A  out  16  signed operand; equals img_rdata.
- mac_B  out  16  signed operand; equals wgt_rdata.
- mac_out  in  32  signed MAC result.
- res_valid  out  1  one-cycle pulse; res_data and res_index are valid.
- res_data  out  32  captured signed result.
- res_index  out  10  output number within the run, starting at 0.

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE.
- Output count and products per output (N):
  - Conv: W_OUT = W-K+1, giving 24x24 = 576 outputs for layer 00 and 8x8 = 64 for layer 01; N = 25.
  - FC: FC_OUTS outputs; N = FC_LEN.
- Addressing for conv output (r,c), tap (i,j), tap order j fastest, then i:
  - img_addr = (r+i)*W + (c+j)
  - wgt_addr = i*K + j
  - Outputs are ordered c fastest, then r; res_index = r*W_OUT + c.
- Addressing for FC output o, element n: img_addr = n; wgt_addr = o*FC_LEN + n.
- States:
  - IDLE: on start with layer != 11, latch layer, pulse mac_clr, go to ISSUE. start with layer = 11 is ignored (busy stays 0, no done). start while busy is ignored.
  - ISSUE: present address t, for t = 0..N-1, one per cycle. mac_enable is asserted one cycle after each address, so it is high for exactly N data cycles. After t = N-1, go to DRAIN.
  - DRAIN: last data cycle (mac_enable = 1). Go to FLUSH.
  - FLUSH: mac_enable = 1; the MAC sees count == N and latches its result. Go to CAPTURE.
  - CAPTURE: mac_enable = 0; res_data <= mac_out; res_valid = 1. If this was the last output, go to DONE; otherwise advance the output index and go to ISSUE.
  - DONE: done = 1 for one cycle, then IDLE; busy drops with done.
- Cycles per output = N+3; latency from start to first res_valid = N+4.
- Address counters are exact; no wrap occurs within a legal run.
- mac_A and mac_B are driven only while mac_enable is high; otherwise they are 0.
- Reset mid-run: the run aborts immediately; no done is pulsed.

Optional Feature:
- Macro: RELU_EN.
- Defined: in CAPTURE, res_data = 0 when mac_out < 0, otherwise mac_out.
- Undefined: res_data = mac_out unmodified, sign preserved.

Test Plan:
- Layer 00, image RAM all 1, weights all 1 -> 576 res_valid pulses; each res_data = 25; res_index runs 0..575; one done; busy high for 576*28+1 cycles.
- Layer 10, img[n] = 1, wgt = 2 for all addresses -> 10 results of 384, each 195 cycles apart; for output o = 9, wgt_addr runs 1728..1919.
- Layer 00, output index 1 -> tap (4,4) shows img_addr = 117, wgt_addr = 24; with img = address value and weights = 0 except w[24] = -1, res_data = -117 (0 with RELU_EN defined).
- Layer 01 -> 64 results; last output (7,7) reads img_addr 0x8F = 143.
- start with layer = 11, or start pulsed while busy -> no state change; no extra res_valid or done.
- reset asserted mid-ISSUE on output 3 -> all outputs 0 next edge; a new start then yields res_index beginning at 0 with correct sums.
